// File: rtl/adc_scan_avg.sv
// Scans a channel range on the modular ADC, averages 2^AVG_LOG2 samples per
// channel, converts the average to millivolts and keeps a per-slot readback bank.
module adc_scan_avg #(
    parameter int NUM_CH   = 6,
    parameter int FIRST_CH = 1,
    parameter int AVG_LOG2 = 2,
    parameter int DATA_W   = 12,
    parameter int VREF_MV  = 5000,
    parameter int MV_W     = 13
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              command_valid,
    output logic [4:0]        command_channel,
    output logic              command_startofpacket,
    output logic              command_endofpacket,
    input  logic              command_ready,
    input  logic              response_valid,
    input  logic [4:0]        response_channel,
    input  logic [DATA_W-1:0] response_data,
    output logic              result_valid,
    output logic [2:0]        result_slot,
    output logic [DATA_W-1:0] result_raw,
    output logic [MV_W-1:0]   result_mv,
    input  logic [2:0]        rd_slot,
    output logic [MV_W-1:0]   rd_mv,
    output logic              mismatch
);
    localparam int NUM_W  = DATA_W + MV_W;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DCNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(NUM_W - 1);
    localparam logic [DATA_W:0]   DIVISOR  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [2:0]        SLOT_LAST = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, DIV, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          slot;
    logic [CNT_W-1:0]    cnt;
    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   avg;
    logic [NUM_W-1:0]    dq;
    logic [DATA_W-1:0]   rem;
    logic [DCNT_W-1:0]   div_cnt;
    logic [MV_W-1:0]     bank [8];

    logic [SUM_W-1:0]    sum_nxt;
    logic [DATA_W:0]     trial;
    logic                q_bit;
    logic [DATA_W:0]     rem_full;
    logic                ch_match;
    logic                last_smp;

    function automatic logic [DATA_W-1:0] avg_of(input logic [SUM_W-1:0] total);
        avg_of = DATA_W'(total >> AVG_LOG2);
    endfunction

    assign command_channel       = 5'(FIRST_CH) + {2'b00, slot};
    assign command_valid         = (state == CMD);
    assign command_startofpacket = 1'b1;
    assign command_endofpacket   = 1'b1;

    assign ch_match = (response_channel == command_channel);
    assign last_smp = (cnt == CNT_LAST);
    assign sum_nxt  = sum + SUM_W'(response_data);

    // Restoring division: dq shifts the numerator out and the quotient in.
    assign trial    = {rem, dq[NUM_W-1]};
    assign q_bit    = (trial >= DIVISOR);
    assign rem_full = q_bit ? (trial - DIVISOR) : trial;

    assign rd_mv = (int'(rd_slot) < NUM_CH) ? bank[rd_slot] : '0;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = CMD;
            CMD:  if (command_ready) state_nxt = WAIT;
            WAIT: if (response_valid && ch_match) state_nxt = last_smp ? DIV : CMD;
            DIV:  if (div_cnt == DIV_LAST) state_nxt = DONE;
            DONE: state_nxt = enable ? CMD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            slot         <= '0;
            cnt          <= '0;
            sum          <= '0;
            avg          <= '0;
            dq           <= '0;
            rem          <= '0;
            div_cnt      <= '0;
            result_valid <= 1'b0;
            result_slot  <= '0;
            result_raw   <= '0;
            result_mv    <= '0;
            mismatch     <= 1'b0;
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            // Any response not consumed as the current channel's sample is dropped.
            mismatch     <= response_valid && !((state == WAIT) && ch_match);
            result_valid <= (state == DONE);
            case (state)
                WAIT: begin
                    if (response_valid && ch_match) begin
                        if (last_smp) begin
                            avg     <= avg_of(sum_nxt);
                            dq      <= NUM_W'(avg_of(sum_nxt)) * NUM_W'(VREF_MV);
                            rem     <= '0;
                            div_cnt <= '0;
                            cnt     <= '0;
                            sum     <= '0;
                        end else begin
                            sum <= sum_nxt;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DIV: begin
                    dq      <= {dq[NUM_W-2:0], q_bit};
                    rem     <= rem_full[DATA_W-1:0];
                    div_cnt <= div_cnt + 1'b1;
                end
                DONE: begin
                    result_slot <= slot;
                    result_raw  <= avg;
                    result_mv   <= dq[MV_W-1:0];
                    bank[slot]  <= dq[MV_W-1:0];
                    slot        <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_avg.sv
// Randomized bench for adc_scan_avg: an ADC responder plus a scoreboard that
// computes each channel's average and millivolt value with plain arithmetic.
`timescale 1ns/1ps
module tb_adc_scan_avg;
    localparam int NUM_CH   = 3;
    localparam int FIRST_CH = 1;
    localparam int AVG_LOG2 = 2;
    localparam int DATA_W   = 12;
    localparam int VREF_MV  = 5000;
    localparam int MV_W     = 13;
    localparam int NUM_W    = DATA_W + MV_W;
    localparam int NSMP     = 1 << AVG_LOG2;

    logic              sys_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              command_valid;
    logic [4:0]        command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready = 1'b0;
    logic              response_valid = 1'b0;
    logic [4:0]        response_channel = '0;
    logic [DATA_W-1:0] response_data = '0;
    logic              result_valid;
    logic [2:0]        result_slot;
    logic [DATA_W-1:0] result_raw;
    logic [MV_W-1:0]   result_mv;
    logic [2:0]        rd_slot = '0;
    logic [MV_W-1:0]   rd_mv;
    logic              mismatch;

    adc_scan_avg #(
        .NUM_CH(NUM_CH), .FIRST_CH(FIRST_CH), .AVG_LOG2(AVG_LOG2),
        .DATA_W(DATA_W), .VREF_MV(VREF_MV), .MV_W(MV_W)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable),
        .command_valid(command_valid), .command_channel(command_channel),
        .command_startofpacket(command_startofpacket),
        .command_endofpacket(command_endofpacket), .command_ready(command_ready),
        .response_valid(response_valid), .response_channel(response_channel),
        .response_data(response_data), .result_valid(result_valid),
        .result_slot(result_slot), .result_raw(result_raw), .result_mv(result_mv),
        .rd_slot(rd_slot), .rd_mv(rd_mv), .mismatch(mismatch)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int slot; int raw; int mv; int t; } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mm_seen = 0;
    int   mm_sent = 0;
    int   exp_slot = 0;
    int   mv_model[NUM_CH];
    int   smp[NSMP];
    logic prev_rv = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_mv(input int raw);
        longint p;
        p = longint'(raw) * VREF_MV;
        return int'(p / ((1 << DATA_W) - 1));
    endfunction

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Result monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (mismatch) mm_seen++;
        if (result_valid) begin
            check_val("rv_back_to_back", {31'd0, prev_rv}, 0);
            if (exp_q.size() == 0) begin
                check_val("spurious_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("result_slot", {29'd0, result_slot}, mon_e.slot);
                check_val("result_raw", {20'd0, result_raw}, mon_e.raw);
                check_val("result_mv", {19'd0, result_mv}, mon_e.mv);
                check_val("result_latency", cyc - mon_e.t, NUM_W + 1);
                mv_model[mon_e.slot] = mon_e.mv;
            end
        end
        prev_rv = result_valid;
    end

    task automatic serve_sample(input int ch, input int d, input bit bad, input bit last);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge sys_clk);
            got = command_valid;
        end
        check_val("cmd_valid", {31'd0, got}, 1);
        check_val("cmd_channel", {27'd0, command_channel}, ch);
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        check_val("cmd_hold", {31'd0, command_valid}, 1);
        command_ready = 1'b1;
        @(negedge sys_clk);
        command_ready = 1'b0;
        check_val("cmd_drop", {31'd0, command_valid}, 0);
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        if (bad) begin
            response_valid   = 1'b1;
            response_channel = 5'(ch + 3);
            response_data    = 12'd999;
            @(negedge sys_clk);
            response_valid = 1'b0;
            mm_sent++;
            check_val("mismatch_pulse", {31'd0, mismatch}, 1);
        end
        response_valid   = 1'b1;
        response_channel = 5'(ch);
        response_data    = DATA_W'(d);
        @(negedge sys_clk);
        response_valid = 1'b0;
        check_val("mismatch_quiet", {31'd0, mismatch}, 0);
        if (!last) check_val("cmd_reissue", {31'd0, command_valid}, 1);
    endtask

    // Serves one full channel from smp[]; push=0 means no result is expected.
    task automatic serve_channel(input bit push, input int drop_after, input logic [3:0] bad_mask);
        int   ch;
        int   total;
        exp_t e;
        ch    = FIRST_CH + exp_slot;
        total = 0;
        for (int i = 0; i < NSMP; i++) begin
            total += smp[i];
            serve_sample(ch, smp[i], bad_mask[i], i == NSMP - 1);
            if (i == drop_after - 1) enable = 1'b0;
        end
        if (push) begin
            e.slot = exp_slot;
            e.raw  = total / NSMP;
            e.mv   = ref_mv(e.raw);
            e.t    = cyc;
            exp_q.push_back(e);
            exp_slot = (exp_slot + 1) % NUM_CH;
        end
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NSMP; i++) smp[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NSMP; i++) smp[i] = $urandom_range(0, (1 << DATA_W) - 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge sys_clk);
        check_val("result_drain", exp_q.size(), 0);
    endtask

    task automatic check_bank();
        for (int s = 0; s < 5; s++) begin
            rd_slot = 3'(s);
            #1;
            check_val("rd_mv", {19'd0, rd_mv}, (s < NUM_CH) ? mv_model[s] : 0);
        end
        rd_slot = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  idle_cv;
        bit  got;
        for (int s = 0; s < NUM_CH; s++) mv_model[s] = 0;

        repeat (3) @(negedge sys_clk);
        check_val("rst_cmd_valid", {31'd0, command_valid}, 0);
        check_val("rst_cmd_channel", {27'd0, command_channel}, FIRST_CH);
        check_val("rst_sop_eop", {30'd0, command_startofpacket, command_endofpacket}, 3);
        check_val("rst_result_valid", {31'd0, result_valid}, 0);
        check_val("rst_result_slot", {29'd0, result_slot}, 0);
        check_val("rst_result_raw", {20'd0, result_raw}, 0);
        check_val("rst_result_mv", {19'd0, result_mv}, 0);
        check_val("rst_mismatch", {31'd0, mismatch}, 0);
        check_bank();

        reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_val("idle_no_cmd", {31'd0, command_valid}, 0);
        enable = 1'b1;

        // Directed channels: full scale, mixed, mid scale, zero, then a dropped sample.
        fill_const(4095);             serve_channel(1, 0, 4'b0000);
        smp = '{100, 200, 300, 400};  serve_channel(1, 0, 4'b0000);
        fill_const(2048);             serve_channel(1, 0, 4'b0000);
        fill_const(0);                serve_channel(1, 0, 4'b0000);
        fill_const(1000);             serve_channel(1, 0, 4'b0001);
        drain();
        check_bank();

        for (int n = 0; n < 6; n++) begin
            fill_rand();
            serve_channel(1, 0, 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end

        // Drop enable mid-channel: the channel finishes, then the scan parks in IDLE.
        fill_rand();
        serve_channel(1, 2, 4'b0000);
        drain();
        idle_cv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (command_valid) idle_cv++;
        end
        check_val("idle_after_drop", idle_cv, 0);
        check_bank();
        enable = 1'b1;
        for (int n = 0; n < 2; n++) begin
            fill_rand();
            serve_channel(1, 0, 4'b0000);
        end
        drain();

        // Reset asserted during the tenth DIV cycle of a channel.
        fill_rand();
        for (int i = 0; i < NSMP; i++) if (smp[i] < 16) smp[i] = 16;
        serve_channel(0, 0, 4'b0000);
        repeat (9) @(negedge sys_clk);
        reset_n = 1'b0;
        #1;
        check_val("arst_result_valid", {31'd0, result_valid}, 0);
        check_val("arst_result_raw", {20'd0, result_raw}, 0);
        check_val("arst_result_mv", {19'd0, result_mv}, 0);
        check_val("arst_result_slot", {29'd0, result_slot}, 0);
        check_val("arst_cmd_valid", {31'd0, command_valid}, 0);
        for (int s = 0; s < NUM_CH; s++) mv_model[s] = 0;
        exp_slot = 0;
        check_bank();
        repeat (30) @(negedge sys_clk);
        reset_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge sys_clk);
            got = command_valid;
        end
        check_val("post_rst_cmd_valid", {31'd0, got}, 1);
        check_val("post_rst_cmd_channel", {27'd0, command_channel}, FIRST_CH);

        // A response with no command outstanding is dropped.
        response_valid   = 1'b1;
        response_channel = 5'(FIRST_CH);
        response_data    = 12'd5;
        @(negedge sys_clk);
        response_valid = 1'b0;
        mm_sent++;
        check_val("late_resp_mismatch", {31'd0, mismatch}, 1);

        for (int n = 0; n < 3; n++) begin
            fill_rand();
            serve_channel(1, 0, 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        drain();
        check_bank();
        repeat (3) @(negedge sys_clk);
        check_val("mismatch_count", mm_seen, mm_sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
